// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with per-digit active-low 7-segment outputs.
// Define COUNTDOWN_BLANK_EN to blank leading-zero digits (digit 0 always shown).

module seg7 (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    // Active-low segments, bit 0 = segment a ... bit 6 = segment g
    always_comb begin
        seg_o = 7'b1111111;
        case (bcd_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = 7'b1111111;
        endcase
    end
endmodule

module bcd_countdown_timer #(
    parameter int DIGITS   = 3,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  running,
    output logic                  expired,
    output logic                  done_pulse
);
    localparam int                PSC_W    = $clog2(TICK_DIV);
    localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] CNT_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [PSC_W-1:0]    psc_q, psc_d;
    logic                running_q, expired_q, done_q;
    logic [DIGITS-1:0]   blank;

    function automatic logic [4*DIGITS-1:0] clamp_bcd(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple-borrow decrement: a zero digit wraps to 9 and keeps borrowing
    function automatic logic [4*DIGITS-1:0] dec_bcd(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        psc_d   = psc_q;
        if (load) begin
            state_d = S_IDLE;
            psc_d   = '0;
            count_d = clamp_bcd(load_value);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!pause && start) begin
                        psc_d   = '0;
                        state_d = (count_q != '0) ? S_RUN : S_EXPIRED;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (psc_q == PSC_LAST) begin
                        psc_d = '0;
                        if (count_q != '0) begin
                            count_d = dec_bcd(count_q);
                            if (count_q == CNT_ONE) state_d = S_EXPIRED;
                        end
                    end else begin
                        psc_d = psc_q + PSC_W'(1);
                    end
                end
                S_PAUSED: begin
                    if (!pause && start) state_d = S_RUN;
                end
                S_EXPIRED: begin
                    count_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            psc_q     <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            psc_q     <= psc_d;
            running_q <= (state_d == S_RUN);
            expired_q <= (state_d == S_EXPIRED);
            done_q    <= (state_d == S_EXPIRED) && (state_q != S_EXPIRED);
        end
    end

`ifdef COUNTDOWN_BLANK_EN
    // Blank from the MSD down until the first nonzero digit; digit 0 never blanks
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead     = lead && (count_q[4*i +: 4] == 4'd0);
            blank[i] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [6:0] seg;
        seg7 u_seg7 (
            .bcd_i (count_q[4*g +: 4]),
            .seg_o (seg)
        );
        assign hex_out[7*g +: 7] = blank[g] ? 7'b1111111 : seg;
    end

    assign bcd_out    = count_q;
    assign running    = running_q;
    assign expired    = expired_q;
    assign done_pulse = done_q;

endmodule
